multicycle_alu: RTL and testbench
=================================

// Module: multicycle_alu
// PURPOSE
//   Parametrised, registered successor to the 4-bit combinational ALU: add, subtract, multiply.
//   Operands are accepted through a valid/ready handshake.
//   Add/sub complete in 1 cycle; multiply uses an iterative shift-add engine of WIDTH cycles.
//   Results are held until the consumer accepts them. Sits between the operand source and the result sink.
// PARAMETERS
//   WIDTH   4   operand width in bits (>=2); product width is 2*WIDTH
// PORTS
//   clk        in   1          rising-edge clock; single clock domain
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          operands/op present on a, b, cin, sel
//   in_ready   out  1          block can accept a new operation
//   a          in   WIDTH      operand A (unsigned)
//   b          in   WIDTH      operand B (unsigned)
//   cin        in   1          carry-in (add) / borrow-in (sub); ignored for mul
//   sel        in   2          00 add, 01 sub, 10 mul, 11 illegal
//   out_valid  out  1          result, cout, err valid
//   out_ready  in   1          consumer accepts result
//   result     out  2*WIDTH    add/sub: zero-extended WIDTH-bit value; mul: full product
//   cout       out  1          add: carry-out; sub: borrow-out; mul/illegal: 0
//   err        out  1          1 = illegal sel (result 0)
// BEHAVIOUR
//   Reset: state IDLE; in_ready=1; out_valid=0; result=0; cout=0; err=0; mul regs cleared.
//   Reset wins over every other event, including mid-multiply or result pending; the op is discarded.
//   FSM IDLE:
//   - in_ready=1. Accept when in_valid && in_ready; operands latched that edge.
//   - add: {cout,result[W-1:0]} = a+b+cin -> DONE.
//   - sub: result[W-1:0] = (a-b-cin) mod 2^W; cout=1 iff a < b+cin (as W+1-bit values) -> DONE.
//   - mul: latch a (multiplicand), b (multiplier), clear acc, count=0 -> MUL.
//   - 11: result=0, cout=0, err=1 -> DONE.
//   FSM MUL:
//   - in_ready=0. Each cycle: if mplier[0], acc += mcand<<count; mplier>>=1; count++.
//   - After WIDTH iterations load result=acc, cout=0, err=0 -> DONE.
//   - No early termination: latency is fixed regardless of operand values.
//   FSM DONE:
//   - out_valid=1, in_ready=0; result/cout/err stable.
//   - On out_ready: out_valid falls next edge -> IDLE.
//   Latency (accept edge to out_valid high): add/sub/illegal 1 cycle; mul WIDTH+1 cycles.
//   Throughput: no overlap; the next accept happens no earlier than the cycle after the result handshake.
//   in_valid while in_ready=0 is ignored (not queued); the source must hold it.
//   out_ready while out_valid=0 has no effect.
//   result and cout retain their last values after the handshake until overwritten.
//   Widths: add/sub upper WIDTH bits of result are 0. The mul accumulator is 2*WIDTH bits and never overflows.
// TESTING
//   (WIDTH=4) add a=9 b=8 cin=1 -> 1 cycle later out_valid=1, result=8'h02, cout=1, err=0.
//   sub a=3 b=5 cin=0 -> result=8'h0E, cout=1; sub a=7 b=2 cin=1 -> result=8'h04, cout=0.
//   mul a=15 b=15 -> out_valid exactly 5 cycles after accept, result=8'hE1, cout=0; in_ready=0 throughout.
//   sel=11 a=5 b=5 -> result=0, err=1, cout=0; next add clears err.
//   Back-pressure: hold out_ready=0 for 10 cycles -> result stable, in_ready=0, new in_valid ignored; release -> IDLE next edge.
//   rst asserted 2 cycles into a mul -> next edge out_valid=0, in_ready=1; following add a=1 b=1 -> result=2.
//   WIDTH=8 regression: mul a=255 b=255 -> 16'hFE01 after 9 cycles.

Source files
------------

// File: rtl/multicycle_alu.sv
// Registered add/sub/mul ALU with valid/ready handshakes on both sides.
// Add, sub and illegal ops finish on the accept edge; mul runs a fixed WIDTH-step shift-add loop.
module multicycle_alu #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  input  logic [1:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 cout,
  output logic                 err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 cout_q;
  logic                 err_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        count_q;

  logic [WIDTH:0]       sum_w;
  logic [WIDTH:0]       diff_w;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_d;

  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    // The (W+1)-bit wrap leaves the borrow in the top bit.
    diff_w = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
    addend = mplier_q[0] ? (mcand_q << count_q) : '0;
    acc_d  = acc_q + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            case (sel)
              2'b00: begin
                result_q    <= {{WIDTH{1'b0}}, sum_w[WIDTH-1:0]};
                cout_q      <= sum_w[WIDTH];
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
              2'b01: begin
                result_q    <= {{WIDTH{1'b0}}, diff_w[WIDTH-1:0]};
                cout_q      <= diff_w[WIDTH];
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
              2'b10: begin
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                acc_q    <= '0;
                count_q  <= '0;
                state_q  <= S_MUL;
              end
              default: begin
                result_q    <= '0;
                cout_q      <= 1'b0;
                err_q       <= 1'b1;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
            endcase
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          // The final step publishes the sum directly so mul latency is WIDTH+1.
          if (count_q == CW'(WIDTH - 1)) begin
            result_q    <= acc_d;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: arithmetic reference model checked every cycle (WIDTH=4),
// directed literal vectors, plus a WIDTH=8 multiply check.
module tb_multicycle_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic [1:0] sel = '0;
  logic       in_ready, out_valid, cout, err;
  logic [7:0] result;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic [1:0]  sel8 = '0;
  logic        in_ready8, out_valid8, cout8, err8;
  logic [15:0] result8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout), .err(err)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sel(sel8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .cout(cout8), .err(err8)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a pending-result flag plus a countdown for multiply.
  bit m_ok = 0, m_busy = 0, m_outv = 0;
  int m_cnt = 0;
  int m_res = 0, p_res = 0;
  bit m_cout = 0, m_err = 0, p_cout = 0, p_err = 0;

  always @(posedge clk) begin
    int s;
    if (rst) begin
      m_ok = 1; m_busy = 0; m_outv = 0; m_res = 0; m_cout = 0; m_err = 0;
    end else if (m_ok) begin
      if (m_outv) begin
        if (out_ready) m_outv = 0;
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_outv = 1; m_res = p_res; m_cout = p_cout; m_err = p_err;
        end
      end else if (in_valid) begin
        p_err = 0; p_cout = 0;
        case (sel)
          2'd0: begin s = int'(a) + int'(b) + int'(cin); p_res = s % 16; p_cout = (s >= 16); end
          2'd1: begin s = int'(a) - int'(b) - int'(cin); p_res = (s + 32) % 16; p_cout = (s < 0); end
          2'd2: p_res = int'(a) * int'(b);
          default: begin p_res = 0; p_err = 1; end
        endcase
        if (sel == 2'd2) begin
          m_busy = 1; m_cnt = 4;
        end else begin
          m_outv = 1; m_res = p_res; m_cout = p_cout; m_err = p_err;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_in_ready", in_ready, !(m_outv || m_busy));
      chk("model_out_valid", out_valid, m_outv);
      chk("model_result", result, m_res);
      chk("model_cout", cout, m_cout);
      chk("model_err", err, m_err);
    end
  end

  task automatic op(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                    input logic [1:0] sv, input int exp_res, input bit exp_cout,
                    input bit exp_err, input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    a = av; b = bv; cin = cv; sel = sv; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      if (sv == 2'd2) chk({name, "_busy_in_ready"}, in_ready, 0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_result"}, result, exp_res);
    chk({name, "_cout"}, cout, exp_cout);
    chk({name, "_err"}, err, exp_err);
    $display("op %s a=%0d b=%0d cin=%0d sel=%0d -> result=%02h cout=%0d err=%0d lat=%0d",
             name, av, bv, cv, sv, result, cout, err, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    op(4'd9,  4'd8,  1'b1, 2'd0, 8'h02, 1, 0, 1, "add_9_8_1");
    op(4'd3,  4'd5,  1'b0, 2'd1, 8'h0E, 1, 0, 1, "sub_3_5_0");
    op(4'd7,  4'd2,  1'b1, 2'd1, 8'h04, 0, 0, 1, "sub_7_2_1");
    op(4'd15, 4'd15, 1'b0, 2'd2, 8'hE1, 0, 0, 5, "mul_15_15");
    op(4'd5,  4'd5,  1'b0, 2'd3, 8'h00, 0, 1, 1, "illegal");
    op(4'd2,  4'd3,  1'b0, 2'd0, 8'h05, 0, 0, 1, "add_clears_err");
    op(4'd15, 4'd15, 1'b1, 2'd0, 8'h0F, 1, 0, 1, "add_15_15_1");
    op(4'd0,  4'd0,  1'b1, 2'd1, 8'h0F, 1, 0, 1, "sub_0_0_1");
    op(4'd8,  4'd8,  1'b0, 2'd1, 8'h00, 0, 0, 1, "sub_8_8_0");
    op(4'd3,  4'd5,  1'b1, 2'd2, 8'h0F, 0, 0, 5, "mul_3_5");
    op(4'd0,  4'd9,  1'b0, 2'd2, 8'h00, 0, 0, 5, "mul_0_9");

    // out_ready while idle must not disturb anything
    @(negedge clk); out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_ready_valid", out_valid, 0);

    // Back-pressure: result held, new requests ignored
    @(negedge clk); a = 4'd6; b = 4'd7; cin = 1'b0; sel = 2'd0; in_valid = 1'b1;
    @(negedge clk); a = 4'd1; b = 4'd2;
    for (int i = 0; i < 10; i++) begin
      chk("bp_result", result, 8'h0D);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    $display("backpressure held result=%02h for 10 cycles", result);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_result", result, 8'h0D);

    // Reset in the middle of a multiply
    @(negedge clk); a = 4'd15; b = 4'd15; sel = 2'd2; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midmul_rst_valid", out_valid, 0);
    chk("midmul_rst_ready", in_ready, 1);
    $display("reset mid-mul -> out_valid=%0d in_ready=%0d", out_valid, in_ready);
    rst = 1'b0;
    op(4'd1, 4'd1, 1'b0, 2'd0, 8'h02, 0, 0, 1, "add_after_rst");

    // WIDTH=8 multiply
    @(negedge clk); a8 = 8'd255; b8 = 8'd255; sel8 = 2'd2; in_valid8 = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); in_valid8 = 1'b0;
    while (!out_valid8 && lat < 30) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("w8_mul_latency", lat, 9);
    chk("w8_mul_result", result8, 16'hFE01);
    chk("w8_mul_cout", cout8, 0);
    $display("op w8_mul a=255 b=255 -> result=%04h lat=%0d", result8, lat);
    out_ready8 = 1'b1;
    @(negedge clk); out_ready8 = 1'b0;
    chk("w8_release", out_valid8, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
